trivium_rand_arbiter: RTL and testbench

Round-robin scheduler that shares one Trivium-based random-word source (128-bit, two 64-bit keystream lanes stepped together) among several masked-datapath consumers (DOM share refresh, nonce generation). It issues the source's seed/start and step strobes, enforces a per-seed word budget with automatic reseed, and delivers each fresh word to exactly one requester. It sits between the Trivium pair and the ASCON DOM cores.

---
 rtl/trivium_rand_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_trivium_rand_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trivium_rand_arbiter.sv
// trivium_rand_arbiter
//
// Round-robin scheduler that shares one Trivium-based random-word source among
// several masked-datapath consumers. Sequences the source's seed and step
// strobes, enforces a per-seed word budget with automatic reseed, and hands
// each freshly stepped word to exactly one requester.
//
// Ports:
//   clk         clock, rising edge
//   RST         asynchronous active-high reset
//   budget      words allowed per seed (0 = unlimited), sampled when seeding ends
//   reseed_req  level request to reseed at the next arbitration cycle
//   src_start   seed/restart strobe to the source (SEED state)
//   src_ready   source seeded indication
//   src_enable  step strobe to the source (STEP state)
//   src_data    source output word, fresh the cycle after src_enable
//   req         level requests, held until the matching rvalid
//   grant       registered one-hot grant, high during STEP and DELIVER
//   rvalid      registered one-cycle delivery pulse
//   rdata       registered delivered word, held until the next delivery
//   words_left  remaining budget for the current seed
//   busy        high in every state except ARB
module trivium_rand_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CNT_W  = 27
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [CNT_W-1:0]  budget,
    input  logic              reseed_req,
    output logic              src_start,
    input  logic              src_ready,
    output logic              src_enable,
    input  logic [DATA_W-1:0] src_data,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  grant,
    output logic [N_REQ-1:0]  rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [CNT_W-1:0]  words_left,
    output logic              busy
);

    localparam int unsigned PtrW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // One extra bit so ptr + offset can be wrapped without overflow.
    localparam int unsigned CandW = PtrW + 1;
    localparam logic [CandW-1:0] NReqW = CandW'(N_REQ);

    typedef enum logic [2:0] {
        StIdle,
        StSeed,
        StWaitSeed,
        StArb,
        StStep,
        StDeliver
    } state_e;

    state_e state_q, state_d;

    logic [PtrW-1:0]   ptr_q;
    logic [PtrW-1:0]   gnt_idx_q;
    logic [CNT_W-1:0]  budget_q;
    logic [CNT_W-1:0]  words_left_q;
    logic [N_REQ-1:0]  grant_q;
    logic [N_REQ-1:0]  rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    logic              limited;
    logic              exhausted;
    logic              pick_found;
    logic [PtrW-1:0]   pick_idx;
    logic [N_REQ-1:0]  pick_oh;
    logic [CandW-1:0]  cand;
    logic [CandW-1:0]  ptr_inc;
    logic              arb_grant;

    // Budget captured at seed time decides whether words_left is enforced.
    assign limited   = (budget_q != '0);
    assign exhausted = limited && (words_left_q == '0);

    // First set request at or above ptr, wrapping modulo N_REQ.
    always_comb begin : rr_pick
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_oh    = '0;
        cand       = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr_q} + CandW'(i);
            if (cand >= NReqW) begin
                cand = cand - NReqW;
            end
            if (!pick_found && req[cand[PtrW-1:0]]) begin
                pick_found                = 1'b1;
                pick_idx                  = cand[PtrW-1:0];
                pick_oh[cand[PtrW-1:0]]   = 1'b1;
            end
        end
    end

    // Pointer moves just past the index being served so it drops to lowest priority.
    always_comb begin : ptr_next
        ptr_inc = {1'b0, gnt_idx_q} + CandW'(1);
        if (ptr_inc >= NReqW) begin
            ptr_inc = '0;
        end
    end

    assign arb_grant = !reseed_req && !exhausted && pick_found;

    // State register
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     state_d = StSeed;
            StSeed:     state_d = StWaitSeed;
            StWaitSeed: begin
                if (src_ready) begin
                    state_d = StArb;
                end
            end
            StArb: begin
                if (reseed_req || exhausted) begin
                    state_d = StSeed;
                end else if (pick_found) begin
                    state_d = StStep;
                end
            end
            StStep:     state_d = StDeliver;
            StDeliver:  state_d = StArb;
            default:    state_d = StIdle;
        endcase
    end

    // Strobes decode from the state register only.
    always_comb begin
        src_start  = (state_q == StSeed);
        src_enable = (state_q == StStep);
        busy       = (state_q != StArb);
    end

    // Datapath registers
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            ptr_q        <= '0;
            gnt_idx_q    <= '0;
            budget_q     <= '0;
            words_left_q <= '0;
            grant_q      <= '0;
            rvalid_q     <= '0;
            rdata_q      <= '0;
        end else begin
            rvalid_q <= '0;
            unique case (state_q)
                StWaitSeed: begin
                    if (src_ready) begin
                        budget_q     <= budget;
                        words_left_q <= budget;
                    end
                end
                StArb: begin
                    if (arb_grant) begin
                        grant_q   <= pick_oh;
                        gnt_idx_q <= pick_idx;
                    end
                end
                StStep: begin
                    if (limited && (words_left_q != '0)) begin
                        words_left_q <= words_left_q - CNT_W'(1);
                    end
                end
                StDeliver: begin
                    rdata_q  <= src_data;
                    rvalid_q <= grant_q;
                    grant_q  <= '0;
                    ptr_q    <= ptr_inc[PtrW-1:0];
                end
                default: ;
            endcase
        end
    end

    assign grant      = grant_q;
    assign rvalid     = rvalid_q;
    assign rdata      = rdata_q;
    assign words_left = words_left_q;

endmodule

// File: tb/tb_trivium_rand_arbiter.sv
// Directed bench for trivium_rand_arbiter. Expected deliveries are queued as
// requests are issued; a negedge monitor pops and checks each rvalid pulse.
module tb_trivium_rand_arbiter;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned CNT_W  = 27;

    logic              clk        = 1'b0;
    logic              RST        = 1'b1;
    logic [CNT_W-1:0]  budget     = CNT_W'(3);
    logic              reseed_req = 1'b0;
    logic              src_ready  = 1'b0;
    logic [DATA_W-1:0] src_data   = '0;
    logic [N_REQ-1:0]  req        = '0;

    logic              src_start;
    logic              src_enable;
    logic [N_REQ-1:0]  grant;
    logic [N_REQ-1:0]  rvalid;
    logic [DATA_W-1:0] rdata;
    logic [CNT_W-1:0]  words_left;
    logic              busy;

    trivium_rand_arbiter #(
        .N_REQ  (N_REQ),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .RST        (RST),
        .budget     (budget),
        .reseed_req (reseed_req),
        .src_start  (src_start),
        .src_ready  (src_ready),
        .src_enable (src_enable),
        .src_data   (src_data),
        .req        (req),
        .grant      (grant),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .words_left (words_left),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N_REQ-1:0]  oh;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec       = 0;
    int          n_err       = 0;
    int unsigned exp_k       = 0;
    int unsigned step_cnt    = 0;
    int unsigned seed_cnt    = 0;
    int          starts_seen = 0;

    function automatic logic [DATA_W-1:0] word(input int unsigned k);
        return {32'hDEADBEEF ^ k, 32'h01234567 + k, 32'hA5A5A5A5, k};
    endfunction

    // Source model: word k appears the cycle after the k-th step strobe;
    // ready drops after start and rises 5 cycles after the start cycle.
    always @(posedge clk) begin
        if (src_enable) begin
            src_data <= word(step_cnt);
            step_cnt <= step_cnt + 1;
        end
        if (src_start) begin
            src_ready <= 1'b0;
            seed_cnt  <= 4;
        end else if (seed_cnt != 0) begin
            seed_cnt <= seed_cnt - 1;
            if (seed_cnt == 1) begin
                src_ready <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (src_start) begin
            starts_seen++;
        end
    end

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Monitor: every delivery must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!RST && rvalid != '0) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_delivery: got rvalid %b, want none", rvalid);
            end else begin
                e = exp_q.pop_front();
                chk("rvalid_id", DATA_W'(rvalid), DATA_W'(e.oh));
                chk("rdata", rdata, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [N_REQ-1:0] oh);
        exp_t e;
        e.oh   = oh;
        e.data = word(exp_k);
        exp_k++;
        exp_q.push_back(e);
    endtask

    task automatic wait_rvalid(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (rvalid != '0) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rvalid_timeout: got no delivery in 40 cycles, want one");
        end
    endtask

    task automatic wait_arb();
        int n;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (!busy) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL arb_timeout: got busy for 40 cycles, want ARB");
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got no finish by 50000, want finish (%0d miscompares)", n_err);
        $fatal(1);
    end

    initial begin
        int n;
        int n_start;
        int starts_before;

        // Reset state
        repeat (3) tick();
        chk("rst_grant", DATA_W'(grant), '0);
        chk("rst_rvalid", DATA_W'(rvalid), '0);
        chk("rst_rdata", rdata, '0);
        chk("rst_words_left", DATA_W'(words_left), '0);
        chk("rst_src_start", DATA_W'(src_start), '0);
        chk("rst_src_enable", DATA_W'(src_enable), '0);
        chk("rst_busy", DATA_W'(busy), DATA_W'(1));

        // Seed sequence: IDLE, SEED, WAIT_SEED x5, ARB at cycle 8
        RST     = 1'b0;
        n_start = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (src_start) n_start++;
            chk($sformatf("seed_busy_c%0d", cyc), DATA_W'(busy), DATA_W'(cyc < 8));
            if (cyc == 2) chk("seed_src_start_c2", DATA_W'(src_start), DATA_W'(1));
            if (cyc == 8) chk("seed_words_left", DATA_W'(words_left), DATA_W'(3));
            if (cyc < 8) tick();
        end
        chk("seed_start_count", DATA_W'(n_start), DATA_W'(1));

        // Single request on bit 1, ptr=0
        push(4'b0010);
        req = 4'b0010;
        tick();
        chk("single_grant_t1", DATA_W'(grant), DATA_W'(4'b0010));
        chk("single_enable_t1", DATA_W'(src_enable), DATA_W'(1));
        tick();
        chk("single_grant_t2", DATA_W'(grant), DATA_W'(4'b0010));
        chk("single_enable_t2", DATA_W'(src_enable), '0);
        chk("single_words_left", DATA_W'(words_left), DATA_W'(2));
        tick();
        chk("single_rvalid_t3", DATA_W'(rvalid), DATA_W'(4'b0010));
        req = '0;
        tick();
        chk("single_rvalid_t4", DATA_W'(rvalid), '0);

        // Bit 3 from ptr=2: ptr then wraps to 0
        push(4'b1000);
        req = 4'b1000;
        wait_rvalid(n);
        req = '0;
        chk("wrap_words_left", DATA_W'(words_left), DATA_W'(1));

        // Reseed into unlimited mode
        tick();
        budget     = '0;
        reseed_req = 1'b1;
        tick();
        reseed_req = 1'b0;
        chk("reseed_src_start", DATA_W'(src_start), DATA_W'(1));
        wait_arb();
        chk("unlim_words_left", DATA_W'(words_left), '0);

        // Round robin, 12 deliveries, unlimited, no reseed
        starts_before = starts_seen;
        for (int d = 0; d < 12; d++) push(N_REQ'(1) << (d % 4));
        req = 4'b1111;
        for (int d = 0; d < 12; d++) begin
            wait_rvalid(n);
            chk($sformatf("rr_gap_%0d", d), DATA_W'(n), DATA_W'(3));
            if (d >= 8) req[d % 4] = 1'b0;
        end
        chk("rr_no_reseed", DATA_W'(starts_seen - starts_before), '0);
        chk("rr_words_left", DATA_W'(words_left), '0);

        // Reseed priority: reseed_req raised during STEP
        tick();
        push(4'b0100);
        push(4'b0001);
        req = 4'b0100;
        tick();
        chk("rsd_enable_step", DATA_W'(src_enable), DATA_W'(1));
        chk("rsd_grant_step", DATA_W'(grant), DATA_W'(4'b0100));
        reseed_req = 1'b1;
        req        = 4'b0101;
        tick();
        chk("rsd_grant_deliver", DATA_W'(grant), DATA_W'(4'b0100));
        chk("rsd_no_start_deliver", DATA_W'(src_start), '0);
        tick();
        chk("rsd_rvalid", DATA_W'(rvalid), DATA_W'(4'b0100));
        req = 4'b0001;
        tick();
        chk("rsd_seed_not_step", DATA_W'(src_start), DATA_W'(1));
        chk("rsd_no_enable", DATA_W'(src_enable), '0);
        reseed_req = 1'b0;
        wait_rvalid(n);
        req = '0;

        // Budget exhaustion with budget=2, sole requester on bit 0
        tick();
        budget     = CNT_W'(2);
        reseed_req = 1'b1;
        tick();
        reseed_req = 1'b0;
        wait_arb();
        chk("bud_words_left_load", DATA_W'(words_left), DATA_W'(2));
        push(4'b0001);
        push(4'b0001);
        push(4'b0001);
        req = 4'b0001;
        wait_rvalid(n);
        chk("bud_words_left_1", DATA_W'(words_left), DATA_W'(1));
        wait_rvalid(n);
        chk("bud_gap_2", DATA_W'(n), DATA_W'(3));
        chk("bud_words_left_0", DATA_W'(words_left), '0);
        tick();
        chk("bud_reseed_start", DATA_W'(src_start), DATA_W'(1));
        wait_rvalid(n);
        chk("bud_resume_gap", DATA_W'(n), DATA_W'(9));
        chk("bud_words_left_reload", DATA_W'(words_left), DATA_W'(1));
        req = '0;

        // Reset asserted in DELIVER
        tick();
        req = 4'b1000;
        tick();
        chk("mid_enable_step", DATA_W'(src_enable), DATA_W'(1));
        tick();
        chk("mid_grant_deliver", DATA_W'(grant), DATA_W'(4'b1000));
        RST = 1'b1;
        #1;
        chk("mid_grant", DATA_W'(grant), '0);
        chk("mid_rvalid", DATA_W'(rvalid), '0);
        chk("mid_rdata", rdata, '0);
        chk("mid_words_left", DATA_W'(words_left), '0);
        chk("mid_busy", DATA_W'(busy), DATA_W'(1));
        tick();
        chk("mid_rvalid_hold", DATA_W'(rvalid), '0);
        exp_k++; // stepped word is lost with the aborted delivery
        RST = 1'b0;
        chk("mid_idle_start", DATA_W'(src_start), '0);
        tick();
        chk("mid_seed_start", DATA_W'(src_start), DATA_W'(1));
        push(4'b1000);
        wait_rvalid(n);
        chk("mid_resume_gap", DATA_W'(n), DATA_W'(9));
        chk("mid_words_left", DATA_W'(words_left), DATA_W'(1));
        req = '0;

        repeat (3) tick();
        chk("queue_drained", DATA_W'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
